// File: rtl/rsa_pkg.sv
// Shared RSA candidate rules: default widths and the conditioning function
// used by both the random buffer and the primality stage.
package rsa_pkg;

    localparam int unsigned CAND_W_DEF = 16;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned CAND_MAX   = 64;

    // Keep the low cw bits, then force the MSB (full size) and LSB (odd).
    function automatic logic [CAND_MAX-1:0] cond_cand(
        input logic [CAND_MAX-1:0] raw,
        input int unsigned         cw
    );
        logic [CAND_MAX-1:0] w_one;
        logic [CAND_MAX-1:0] w_mask;
        w_one  = CAND_MAX'(1);
        w_mask = (w_one << cw) - w_one;
        return (raw & w_mask) | (w_one << (cw - 1)) | w_one;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; push while full is accepted only when a pop happens
// in the same cycle, pops while empty are ignored.
module sync_fifo #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_data,
    output logic [W-1:0]               o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst && w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/rnd_cand_buf.sv
// Conditions LFSR words into odd full-size candidates, filters back-to-back
// duplicates and queues them for the primality stage.
module rnd_cand_buf
    import rsa_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CAND_W = CAND_W_DEF,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CAND_W-1:0]          out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic [CNT_W-1:0]           dup_cnt
);

    logic [CAND_W-1:0] w_cand;
    logic [CAND_W-1:0] r_last_cand;
    logic              r_last_vld;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic [CNT_W-1:0]  r_dup_cnt;
    logic              w_pop;
    logic              w_dup;
    logic              w_new;
    logic              w_drop;
    logic              w_unused_data;

    assign w_unused_data = ^in_data;

    assign w_cand = CAND_W'(cond_cand(CAND_MAX'(in_data[CAND_W-1:0]), CAND_W));

    assign out_valid = !empty;
    assign w_pop     = out_valid && out_ready;
    assign w_dup     = in_valid && r_last_vld && (w_cand == r_last_cand);
    assign w_new     = in_valid && !w_dup;
    assign w_drop    = w_new && full && !w_pop;

    sync_fifo #(
        .W     (CAND_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_new),
        .i_pop   (w_pop),
        .i_data  (w_cand),
        .o_data  (out_data),
        .o_full  (full),
        .o_empty (empty),
        .o_level (level)
    );

    // Dropped candidates still become the duplicate reference.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_vld <= 1'b0;
            r_drop_cnt <= '0;
            r_dup_cnt  <= '0;
        end else begin
            if (w_new) r_last_vld <= 1'b1;
            if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
            if (w_dup && r_dup_cnt != '1)   r_dup_cnt  <= r_dup_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_new) r_last_cand <= w_cand;
    end

    assign drop_cnt = r_drop_cnt;
    assign dup_cnt  = r_dup_cnt;

endmodule

// File: tb/tb_rnd_cand_buf.sv
// Directed bench for rnd_cand_buf: queue-based reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_rnd_cand_buf;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic [15:0] out_data;
    logic [3:0]  level;
    logic        full;
    logic        empty;
    logic [15:0] drop_cnt;
    logic [15:0] dup_cnt;

    rnd_cand_buf #(.DATA_W(32), .CAND_W(16), .DEPTH(DEPTH), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .full(full), .empty(empty),
        .drop_cnt(drop_cnt), .dup_cnt(dup_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a queue of candidates plus the last-seen candidate.
    logic [15:0] m_q[$];
    logic [15:0] m_last;
    bit          m_last_vld;
    int unsigned m_drop, m_dup, m_pops;
    bit          m_pop;
    logic [15:0] m_c;
    bit          cmp_en = 1'b0;

    function automatic logic [15:0] mcand(input logic [31:0] d);
        logic [15:0] lo;
        lo = d[15:0];
        return lo | 16'h8001;
    endfunction

    initial m_pops = 0;

    always @(posedge clk) begin
        if (!rst) begin
            m_q.delete();
            m_last_vld = 1'b0;
            m_drop     = 0;
            m_dup      = 0;
        end else begin
            m_pop = (m_q.size() != 0) && out_ready;
            if (m_pop) begin
                void'(m_q.pop_front());
                m_pops++;
            end
            if (in_valid) begin
                m_c = mcand(in_data);
                if (m_last_vld && m_c == m_last) begin
                    if (m_dup < 65535) m_dup++;
                end else begin
                    m_last     = m_c;
                    m_last_vld = 1'b1;
                    if (m_q.size() < DEPTH) m_q.push_back(m_c);
                    else if (m_drop < 65535) m_drop++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_out_valid", 32'(out_valid), 32'(m_q.size() != 0));
            chk("m_empty",     32'(empty),     32'(m_q.size() == 0));
            chk("m_full",      32'(full),      32'(m_q.size() == DEPTH));
            chk("m_level",     32'(level),     32'(m_q.size()));
            chk("m_drop_cnt",  32'(drop_cnt),  32'(m_drop));
            chk("m_dup_cnt",   32'(dup_cnt),   32'(m_dup));
            if (m_q.size() != 0) chk("m_out_data", 32'(out_data), 32'(m_q[0]));
        end
    end

    task automatic cyc(input logic v, input logic [31:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    int unsigned pops0;
    int unsigned guard;

    initial begin
        rst = 1'b0;
        cyc(0, '0, 0);
        cyc(0, '0, 0);
        rst = 1'b1;
        cmp_en = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_empty",     32'(empty),     32'd1);
        chk("rst_full",      32'(full),      32'd0);
        chk("rst_level",     32'(level),     32'd0);
        chk("rst_drop",      32'(drop_cnt),  32'd0);
        chk("rst_dup",       32'(dup_cnt),   32'd0);

        cyc(1, 32'h0000_1234, 0);
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_data",  32'(out_data),  32'h9235);
        chk("basic_level", 32'(level),     32'd1);

        cyc(1, 32'hABCD_0000, 0);
        cyc(0, '0, 1);
        chk("cond_data",  32'(out_data), 32'h8001);
        chk("cond_level", 32'(level),    32'd1);
        cyc(1, 32'hABCD_0000, 0);
        chk("dup_cnt",   32'(dup_cnt), 32'd1);
        chk("dup_level", 32'(level),   32'd1);
        cyc(0, '0, 1);
        chk("drain1_empty", 32'(empty), 32'd1);

        for (int i = 1; i <= 9; i++) begin
            cyc(1, 32'(i << 4), 0);
            if (i == 8) chk("fill_full8", 32'(full), 32'd1);
        end
        chk("ovf_drop",  32'(drop_cnt), 32'd1);
        chk("ovf_level", 32'(level),    32'd8);
        for (int i = 1; i <= 8; i++) begin
            chk("ovf_order", 32'(out_data), 32'((i << 4) | 16'h8001));
            cyc(0, '0, 1);
        end
        chk("ovf_drained", 32'(empty), 32'd1);

        for (int i = 16; i <= 23; i++) cyc(1, 32'(i << 4), 0);
        cyc(1, 32'h0000_0AA0, 1);
        chk("fullpop_drop",  32'(drop_cnt), 32'd1);
        chk("fullpop_level", 32'(level),    32'd8);
        for (int i = 17; i <= 23; i++) begin
            chk("fullpop_order", 32'(out_data), 32'((i << 4) | 16'h8001));
            cyc(0, '0, 1);
        end
        chk("fullpop_last", 32'(out_data), 32'h8AA1);
        cyc(0, '0, 1);

        pops0 = m_pops;
        for (int i = 0; i < 20; i++)
            cyc(1, 32'h2000 + 32'(i * 2), (m_q.size() >= 6) ? 1'b1 : 1'($urandom_range(0, 1)));
        guard = 0;
        while (!empty && guard < 40) begin
            cyc(0, '0, 1);
            guard++;
        end
        chk("wrap_level", 32'(level),        32'd0);
        chk("wrap_pops",  m_pops - pops0,    32'd20);
        chk("wrap_drop",  32'(drop_cnt),     32'd1);

        for (int i = 0; i < 5; i++) cyc(1, 32'h3000 + 32'(i * 16), 0);
        chk("pre_rst_level", 32'(level),   32'd5);
        chk("pre_rst_dup",   32'(dup_cnt), 32'd1);
        rst = 1'b0;
        cyc(1, 32'h3040, 1);
        rst = 1'b1;
        chk("mid_rst_empty", 32'(empty),    32'd1);
        chk("mid_rst_level", 32'(level),    32'd0);
        chk("mid_rst_drop",  32'(drop_cnt), 32'd0);
        chk("mid_rst_dup",   32'(dup_cnt),  32'd0);
        cyc(1, 32'h3040, 0);
        chk("post_rst_level", 32'(level),    32'd1);
        chk("post_rst_dup",   32'(dup_cnt),  32'd0);
        chk("post_rst_data",  32'(out_data), 32'hB041);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
